ace_snoop_responder: RTL and testbench
======================================

# ace_snoop_responder

Cache-side ACE snoop responder, sitting between the snoop crossbar and one cached master's tag/data arrays. It accepts AC snoop requests and looks up the line state. It answers on CR, streams the line on CD when data transfer is required, then writes back the new line state. It is the far end of the CCU's AC/CR/CD snoop exchange. It handles one snoop at a time.

## Interface
Parameters:
- snoop_req_t, logic: AC/CR-ready/CD-ready bundle (fields ac_valid, ac{addr,snoop,prot}, cr_ready, cd_ready).
- snoop_resp_t, logic: bundle with ac_ready, cr_valid, cr_resp{WasUnique,IsShared,PassDirty,Error,DataTransfer}, cd_valid, cd{data,last}.
- AddrWidth, 64: snoop/lookup address width.
- DataWidth, 64: CD beat width.
- LineBytes, 64: cache line size; Beats = LineBytes*8/DataWidth (≥1, power of two).

Ports:
- clk_i  in  1  clock; everything sampled on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- snoop_req_i  in  snoop_req_t  AC request plus CR/CD ready from the crossbar.
- snoop_resp_o  out  snoop_resp_t  AC ready, CR response, CD beats.
- lkp_valid_o / lkp_ready_i  out/in  1  tag lookup request handshake.
- lkp_addr_o  out  AddrWidth  line-aligned address (low log2(LineBytes) bits zero).
- lkp_rvalid_i  in  1  lookup result strobe, one cycle.
- lkp_state_i  in  3  {unique, dirty, valid} of the addressed line.
- dat_req_valid_o / dat_req_ready_i  out/in  1  line read request; uses lkp_addr_o.
- dat_valid_i / dat_ready_o  in/out  1  data beat stream from the array.
- dat_data_i  in  DataWidth  beat data, ascending beat order.
- upd_valid_o / upd_ready_i  out/in  1  state write-back handshake.
- upd_state_o  out  3  new {unique, dirty, valid}.
- lkp_err_i  in  1  lookup error (only with ACE_SNOOP_RESP_ERR_EN).

## Operation
FSM states: IDLE, LOOKUP, RESP, DATA, UPDATE.

- **IDLE:** ac_ready=1. On AC handshake:
  - latch addr and snoop code;
  - go to LOOKUP.
- **LOOKUP:** lkp_valid_o=1 until lkp_ready_i. Then wait for lkp_rvalid_i. On lkp_rvalid_i:
  - latch state;
  - compute CR and new state;
  - go to RESP.
- **RESP:** cr_valid=1 until cr_ready.
  - If DataTransfer=1, dat_req_valid_o is raised in the same cycles.
  - Exit only when CR has handshaken and the data request has handshaken (either order).
  - Exit goes to DATA if DataTransfer=1, otherwise to UPDATE.
- **DATA:** pass-through. cd_valid=dat_valid_i, dat_ready_o=cd_ready, cd.data=dat_data_i.
  - Beat counter is clog2(Beats) bits, cleared on entry.
  - cd.last=1 when counter==Beats-1.
  - A last-beat handshake goes to UPDATE.
- **UPDATE:** upd_valid_o=1 until upd_ready_i, then IDLE. Skipped straight to IDLE when the new state equals the old state.

Response table (v/d/u = line bits; miss = !v):
- **Miss, any snoop:** CR=0; no CD; no update.
- **ReadOnce:** DataTransfer=1, IsShared=1, PassDirty=0; state unchanged.
- **ReadShared / ReadClean / ReadNotSharedDirty:**
  - CR: DataTransfer=1, IsShared=1, PassDirty=d.
  - New state: {0,0,1}.
- **ReadUnique / CleanInvalid:**
  - CR: DataTransfer=d for CleanInvalid and 1 for ReadUnique; PassDirty=d; IsShared=0.
  - New state: 0.
- **CleanShared:**
  - CR: DataTransfer=d, PassDirty=d, IsShared=1.
  - New state: {u,0,1}.
- **MakeInvalid:** CR=0 apart from WasUnique; new state 0.
- **Other codes:** CR=0; no update.
- **WasUnique:** = u on every hit.

## Timing
- **Reset values:**
  - state IDLE;
  - ac_ready=1 (follows state);
  - cr_valid, cd_valid, lkp_valid_o, dat_req_valid_o, upd_valid_o, dat_ready_o all 0;
  - CR/CD payload 0.
- **Latency:**
  - lkp_valid_o asserts the cycle after the AC handshake.
  - cr_valid asserts the cycle after lkp_rvalid_i.
  - Minimum AC-to-CR latency is 3 cycles with lkp_ready_i=1 and 1-cycle lookup.
- **Handshakes:** all valids are registered, held stable until ready, and never depend combinationally on their own ready. The exception is the DATA pass-through, which is combinational by design.
- **Back-to-back:** the next AC is accepted no earlier than the cycle after returning to IDLE.
- **Ignored strobes:** lkp_rvalid_i outside LOOKUP and dat_valid_i outside DATA are ignored.
- **Reset mid-operation:** rst_i high on any edge returns to IDLE and clears every valid at that edge. In-flight array responses are dropped.
- **Beats=1:** the first beat carries cd.last=1.

## Configuration
- **ACE_SNOOP_RESP_ERR_EN defined:**
  - lkp_err_i exists. When it is high with lkp_rvalid_i: CR.Error=1 and the table's DataTransfer still applies.
  - CD beats are driven with data=0 while still consuming dat_valid_i.
  - No state update.
- **Undefined:** port absent; Error is tied to 0.

## Structure
- ace_pkg gains:
  - cache_state_t (packed unique/dirty/valid);
  - CR field-position constants;
  - the existing snoop code enum and cr_resp type are reused.
- One combinational sub-module: ace_snoop_decision. Inputs are snoop code, cache_state_t and error. Outputs are cr_resp, new state and update-needed.

## Test plan
- Miss: AC ReadShared addr 0x1000, lkp_state=000 → CR=0 three cycles after AC, no CD, upd_valid_o never asserts.
- Dirty share: ReadShared, state=111, Beats=8, data 0..7 → CR {WasUnique=1,IsShared=1,PassDirty=1,DataTransfer=1}; 8 CD beats 0..7, last on beat 7; upd_state_o=001.
- CD backpressure: ReadUnique, state=101, cd_ready toggling every cycle → beats in order, none lost or duplicated; upd_state_o=000.
- CleanShared on clean line (state=101): CR IsShared=1, WasUnique=1, DataTransfer=0; no update.
- cr_ready held low 10 cycles with dat_req_ready_i=1 → cr_valid and payload stable; DATA not entered until the CR handshake.
- rst_i pulsed mid-DATA after beat 3 → all valids 0 next edge; a new AC is accepted and completes normally.

Source files
------------

// File: rtl/ace_pkg.sv
// ACE snoop-channel types shared by the snoop responder and its decision logic.
package ace_pkg;

   localparam int unsigned AceAddrWidth = 64;
   localparam int unsigned AceDataWidth = 64;

   // Bit positions of the CR response fields inside cr_resp_t.
   localparam int unsigned CrDataTransfer = 0;
   localparam int unsigned CrError        = 1;
   localparam int unsigned CrPassDirty    = 2;
   localparam int unsigned CrIsShared     = 3;
   localparam int unsigned CrWasUnique    = 4;

   typedef enum logic [3:0] {
      SNP_READ_ONCE          = 4'b0000,
      SNP_READ_SHARED        = 4'b0001,
      SNP_READ_CLEAN         = 4'b0010,
      SNP_READ_NOT_SHR_DIRTY = 4'b0011,
      SNP_READ_UNIQUE        = 4'b0111,
      SNP_CLEAN_SHARED       = 4'b1000,
      SNP_CLEAN_INVALID      = 4'b1001,
      SNP_MAKE_INVALID       = 4'b1101
   } ac_snoop_e;

   typedef struct packed {
      logic WasUnique;
      logic IsShared;
      logic PassDirty;
      logic Error;
      logic DataTransfer;
   } cr_resp_t;

   typedef struct packed {
      logic is_unique;
      logic dirty;
      logic valid;
   } cache_state_t;

   typedef struct packed {
      logic [AceAddrWidth-1:0] addr;
      logic [3:0]              snoop;
      logic [2:0]              prot;
   } ac_chan_t;

   typedef struct packed {
      logic [AceDataWidth-1:0] data;
      logic                    last;
   } cd_chan_t;

   typedef struct packed {
      logic     ac_valid;
      ac_chan_t ac;
      logic     cr_ready;
      logic     cd_ready;
   } ace_snoop_req_t;

   typedef struct packed {
      logic     ac_ready;
      logic     cr_valid;
      cr_resp_t cr_resp;
      logic     cd_valid;
      cd_chan_t cd;
   } ace_snoop_resp_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_RESP,
      ST_DATA,
      ST_UPDATE
   } snp_state_e;

endpackage

// File: rtl/ace_snoop_decision.sv
// Combinational snoop response table: CR bits, next line state, write-back need.
module ace_snoop_decision
   import ace_pkg::*;
(
   input  logic [3:0]   snoop_i,
   input  cache_state_t state_i,
   input  logic         err_i,
   output cr_resp_t     cr_o,
   output cache_state_t new_state_o,
   output logic         upd_o
);

   // Table lookup; a miss or an unknown code leaves CR clear and the line untouched.
   always_comb begin
      cr_o        = '0;
      new_state_o = state_i;
      if (state_i.valid) begin
         cr_o.WasUnique = state_i.is_unique;
         case (snoop_i)
            SNP_READ_ONCE: begin
               cr_o.DataTransfer = 1'b1;
               cr_o.IsShared     = 1'b1;
            end
            SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHR_DIRTY: begin
               cr_o.DataTransfer = 1'b1;
               cr_o.IsShared     = 1'b1;
               cr_o.PassDirty    = state_i.dirty;
               new_state_o       = cache_state_t'(3'b001);
            end
            SNP_READ_UNIQUE: begin
               cr_o.DataTransfer = 1'b1;
               cr_o.PassDirty    = state_i.dirty;
               new_state_o       = '0;
            end
            SNP_CLEAN_INVALID: begin
               cr_o.DataTransfer = state_i.dirty;
               cr_o.PassDirty    = state_i.dirty;
               new_state_o       = '0;
            end
            SNP_CLEAN_SHARED: begin
               cr_o.DataTransfer = state_i.dirty;
               cr_o.PassDirty    = state_i.dirty;
               cr_o.IsShared     = 1'b1;
               new_state_o       = cache_state_t'({state_i.is_unique, 2'b01});
            end
            SNP_MAKE_INVALID: begin
               new_state_o = '0;
            end
            default: begin
               cr_o = '0;
            end
         endcase
      end
      cr_o.Error = err_i;
      // An errored lookup never writes the line state back.
      upd_o = !err_i && (new_state_o != state_i);
   end

endmodule

// File: rtl/ace_snoop_responder.sv
// Cache-side ACE snoop responder: AC accept, tag lookup, CR answer, CD line
// stream, state write-back. One snoop in flight at a time.
// Optional feature macro: ACE_SNOOP_RESP_ERR_EN adds lkp_err_i; an errored
// lookup sets CR.Error, zeroes CD data and suppresses the state update.
//
// Handshake rule: every *_valid below is a register, raised without looking at
// its ready, held with its payload until valid&&ready at a rising edge, then
// dropped. The DATA state alone is a combinational pass-through between the
// array beat stream and CD.
module ace_snoop_responder
   import ace_pkg::*;
#(
   parameter type         snoop_req_t  = ace_snoop_req_t,
   parameter type         snoop_resp_t = ace_snoop_resp_t,
   parameter int unsigned AddrWidth    = 64,
   parameter int unsigned DataWidth    = 64,
   parameter int unsigned LineBytes    = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  snoop_req_t           snoop_req_i,
   output snoop_resp_t          snoop_resp_o,
   output logic                 lkp_valid_o,
   input  logic                 lkp_ready_i,
   output logic [AddrWidth-1:0] lkp_addr_o,
   input  logic                 lkp_rvalid_i,
   input  logic [2:0]           lkp_state_i,
   output logic                 dat_req_valid_o,
   input  logic                 dat_req_ready_i,
   input  logic                 dat_valid_i,
   output logic                 dat_ready_o,
   input  logic [DataWidth-1:0] dat_data_i,
   output logic                 upd_valid_o,
   input  logic                 upd_ready_i,
   output logic [2:0]           upd_state_o
`ifdef ACE_SNOOP_RESP_ERR_EN
   ,
   input  logic                 lkp_err_i
`endif
);

   localparam int unsigned Beats = LineBytes * 8 / DataWidth;
   localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
   localparam int unsigned OffW  = $clog2(LineBytes);

   snp_state_e             state_q;
   logic [AddrWidth-1:0]   addr_q;
   logic [3:0]             snoop_q;
   cr_resp_t               cr_q;
   cache_state_t           new_state_q;
   logic                   upd_q, err_q;
   logic                   lkp_valid_q, cr_valid_q, dreq_valid_q, upd_valid_q;
   logic [BeatW-1:0]       beat_q;

   cr_resp_t               dec_cr;
   cache_state_t           dec_state;
   logic                   dec_upd;
   logic                   lkp_err;
   logic                   cr_done, dreq_done, beat_last;
   logic                   unused_req_bits;

`ifdef ACE_SNOOP_RESP_ERR_EN
   assign lkp_err = lkp_err_i;
`else
   assign lkp_err = 1'b0;
`endif

   ace_snoop_decision u_decision (
      .snoop_i     (snoop_q),
      .state_i     (cache_state_t'(lkp_state_i)),
      .err_i       (lkp_err),
      .cr_o        (dec_cr),
      .new_state_o (dec_state),
      .upd_o       (dec_upd)
   );

   assign cr_done   = !cr_valid_q || snoop_req_i.cr_ready;
   assign dreq_done = !dreq_valid_q || dat_req_ready_i;
   assign beat_last = (beat_q == BeatW'(Beats - 1));
   assign unused_req_bits = ^{snoop_req_i.ac.prot, snoop_req_i.ac.addr[OffW-1:0]};

   // Snoop sequencing FSM with all handshake valids registered here.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         snoop_q      <= '0;
         cr_q         <= '0;
         new_state_q  <= '0;
         upd_q        <= 1'b0;
         err_q        <= 1'b0;
         lkp_valid_q  <= 1'b0;
         cr_valid_q   <= 1'b0;
         dreq_valid_q <= 1'b0;
         upd_valid_q  <= 1'b0;
         beat_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (snoop_req_i.ac_valid) begin
                  addr_q      <= {snoop_req_i.ac.addr[AddrWidth-1:OffW], {OffW{1'b0}}};
                  snoop_q     <= snoop_req_i.ac.snoop;
                  lkp_valid_q <= 1'b1;
                  state_q     <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (lkp_valid_q) begin
                  if (lkp_ready_i) lkp_valid_q <= 1'b0;
               end else if (lkp_rvalid_i) begin
                  cr_q         <= dec_cr;
                  new_state_q  <= dec_state;
                  upd_q        <= dec_upd;
                  err_q        <= lkp_err;
                  cr_valid_q   <= 1'b1;
                  dreq_valid_q <= dec_cr.DataTransfer;
                  state_q      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (cr_valid_q && snoop_req_i.cr_ready) cr_valid_q <= 1'b0;
               if (dreq_valid_q && dat_req_ready_i) dreq_valid_q <= 1'b0;
               if (cr_done && dreq_done) begin
                  if (cr_q.DataTransfer) begin
                     beat_q  <= '0;
                     state_q <= ST_DATA;
                  end else if (upd_q) begin
                     upd_valid_q <= 1'b1;
                     state_q     <= ST_UPDATE;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_DATA: begin
               if (dat_valid_i && snoop_req_i.cd_ready) begin
                  beat_q <= beat_q + BeatW'(1);
                  if (beat_last) begin
                     if (upd_q) begin
                        upd_valid_q <= 1'b1;
                        state_q     <= ST_UPDATE;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end
               end
            end
            ST_UPDATE: begin
               if (upd_ready_i) begin
                  upd_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Output assembly; CD mirrors the array stream only while in DATA.
   always_comb begin
      snoop_resp_o          = '0;
      snoop_resp_o.ac_ready = (state_q == ST_IDLE);
      snoop_resp_o.cr_valid = cr_valid_q;
      snoop_resp_o.cr_resp  = cr_q;
      if (state_q == ST_DATA) begin
         snoop_resp_o.cd_valid = dat_valid_i;
         snoop_resp_o.cd.data  = err_q ? '0 : AceDataWidth'(dat_data_i);
         snoop_resp_o.cd.last  = beat_last;
      end
   end

   assign dat_ready_o     = (state_q == ST_DATA) && snoop_req_i.cd_ready;
   assign lkp_valid_o     = lkp_valid_q;
   assign lkp_addr_o      = addr_q;
   assign dat_req_valid_o = dreq_valid_q;
   assign upd_valid_o     = upd_valid_q;
   assign upd_state_o     = new_state_q;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Bench for ace_snoop_responder: a cycle-stepped environment models the
// crossbar, tag array and data array; expected CR/CD/update/lookup values are
// queued when each snoop is issued and compared as the DUT hands them over.
module tb_ace_snoop_responder;
   import ace_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic            rst_i;
   ace_snoop_req_t  snoop_req_i;
   ace_snoop_resp_t snoop_resp_o;
   logic            lkp_valid_o, lkp_ready_i, lkp_rvalid_i;
   logic [63:0]     lkp_addr_o;
   logic [2:0]      lkp_state_i;
   logic            dat_req_valid_o, dat_req_ready_i, dat_valid_i, dat_ready_o;
   logic [63:0]     dat_data_i;
   logic            upd_valid_o, upd_ready_i;
   logic [2:0]      upd_state_o;

   ace_snoop_responder dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .snoop_req_i     (snoop_req_i),
      .snoop_resp_o    (snoop_resp_o),
      .lkp_valid_o     (lkp_valid_o),
      .lkp_ready_i     (lkp_ready_i),
      .lkp_addr_o      (lkp_addr_o),
      .lkp_rvalid_i    (lkp_rvalid_i),
      .lkp_state_i     (lkp_state_i),
      .dat_req_valid_o (dat_req_valid_o),
      .dat_req_ready_i (dat_req_ready_i),
      .dat_valid_i     (dat_valid_i),
      .dat_ready_o     (dat_ready_o),
      .dat_data_i      (dat_data_i),
      .upd_valid_o     (upd_valid_o),
      .upd_ready_i     (upd_ready_i),
      .upd_state_o     (upd_state_o)
`ifdef ACE_SNOOP_RESP_ERR_EN
      ,
      .lkp_err_i       (1'b0)
`endif
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   logic [4:0]  cr_exp_q[$];
   logic [64:0] cd_exp_q[$];
   logic [2:0]  upd_exp_q[$];
   logic [63:0] addr_exp_q[$];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- environment state ----------------
   logic        rst_pend = 1'b1;
   logic        ac_pend = 1'b0;
   logic [63:0] ac_addr_v = '0;
   logic [3:0]  ac_snoop_v = '0;
   logic        rv_next = 1'b0;
   logic [2:0]  line_state = '0;
   logic        dat_active = 1'b0;
   int          beat_idx = 0;
   logic [63:0] data_base = '0;
   int          cr_hold = 0;
   int          dreq_hold = 0;
   logic        cd_toggle = 1'b0;
   logic        cd_tog = 1'b1;
   int          ac_cyc = 0;
   logic        lat_chk = 1'b1;
   logic        lkp_first = 1'b0;
   logic        cr_first = 1'b0;
   logic        cr_done_flag = 1'b1;
   logic        cr_stall_prev = 1'b0;
   logic [4:0]  cr_prev = '0;
   int          cd_count = 0;

   // ---------------- driver: one clock of environment ----------------
   task automatic step();
      @(negedge clk);
      rst_i                = rst_pend;
      snoop_req_i.ac_valid = ac_pend;
      snoop_req_i.ac.addr  = ac_addr_v;
      snoop_req_i.ac.snoop = ac_snoop_v;
      snoop_req_i.ac.prot  = 3'b010;
      lkp_ready_i          = 1'b1;
      lkp_rvalid_i         = rv_next;
      rv_next              = 1'b0;
      lkp_state_i          = line_state;
      snoop_req_i.cr_ready = (cr_hold == 0);
      dat_req_ready_i      = (dreq_hold == 0);
      if (dreq_hold > 0) dreq_hold--;
      dat_valid_i          = dat_active;
      dat_data_i           = data_base + 64'(beat_idx);
      cd_tog               = cd_toggle ? ~cd_tog : 1'b1;
      snoop_req_i.cd_ready = cd_tog;
      upd_ready_i          = ($urandom_range(0, 2) != 0);
      #1;
      if (!rst_pend) begin
         if (snoop_req_i.ac_valid && snoop_resp_o.ac_ready) begin
            ac_pend      = 1'b0;
            ac_cyc       = cyc;
            lkp_first    = 1'b1;
            cr_first     = 1'b1;
            cr_done_flag = 1'b0;
         end else if (!cr_done_flag && dat_active) begin
            check("cd_before_cr", snoop_resp_o.cd_valid, 1'b0);
         end
         if (lkp_first && lkp_valid_o) begin
            check("lkp_latency", cyc - ac_cyc, 1);
            lkp_first = 1'b0;
         end
         if (lkp_valid_o && lkp_ready_i) begin
            rv_next = 1'b1;
            if (addr_exp_q.size() == 0) check("lkp_unexpected", 1, 0);
            else check("lkp_addr", lkp_addr_o, addr_exp_q.pop_front());
         end
         if (snoop_resp_o.cr_valid) begin
            if (cr_first) begin
               if (lat_chk) check("cr_latency", cyc - ac_cyc, 3);
               cr_first = 1'b0;
            end
            if (cr_stall_prev) check("cr_stable", snoop_resp_o.cr_resp, cr_prev);
            if (snoop_req_i.cr_ready) begin
               cr_stall_prev = 1'b0;
               cr_done_flag  = 1'b1;
               if (cr_exp_q.size() == 0) check("cr_unexpected", 1, 0);
               else check("cr_resp", snoop_resp_o.cr_resp, cr_exp_q.pop_front());
            end else begin
               cr_stall_prev = 1'b1;
               cr_prev       = snoop_resp_o.cr_resp;
               if (cr_hold > 0) cr_hold--;
            end
         end else if (cr_stall_prev) begin
            check("cr_valid_held", 0, 1);
            cr_stall_prev = 1'b0;
         end
         if (snoop_resp_o.cd_valid && snoop_req_i.cd_ready) begin
            cd_count++;
            if (cd_exp_q.size() == 0) check("cd_unexpected", 1, 0);
            else check("cd_beat", {snoop_resp_o.cd.last, snoop_resp_o.cd.data}, cd_exp_q.pop_front());
         end
         if (dat_valid_i && dat_ready_o) begin
            beat_idx++;
            if (beat_idx == 8) dat_active = 1'b0;
         end
         if (dat_req_valid_o && dat_req_ready_i) begin
            dat_active = 1'b1;
            beat_idx   = 0;
         end
         if (upd_valid_o && upd_ready_i) begin
            if (upd_exp_q.size() == 0) check("upd_unexpected", 1, 0);
            else check("upd_state", upd_state_o, upd_exp_q.pop_front());
         end
      end
   endtask

   // Queue the expectations of one snoop and launch its AC request.
   task automatic issue(input logic [63:0] addr, input logic [3:0] snp, input logic [2:0] st,
                        input logic [4:0] exp_cr, input bit exp_upd, input logic [2:0] exp_ns,
                        input logic [63:0] base);
      line_state = st;
      data_base  = base;
      cd_count   = 0;
      addr_exp_q.push_back({addr[63:6], 6'b0});
      cr_exp_q.push_back(exp_cr);
      if (exp_cr[CrDataTransfer])
         for (int k = 0; k < 8; k++) cd_exp_q.push_back({(k == 7), base + 64'(k)});
      if (exp_upd) upd_exp_q.push_back(exp_ns);
      ac_addr_v  = addr;
      ac_snoop_v = snp;
      ac_pend    = 1'b1;
   endtask

   task automatic wait_idle(input string tag);
      int  n;
      bit  started;
      n = 0;
      started = 0;
      while (n < 300) begin
         step();
         n++;
         if (started && snoop_resp_o.ac_ready) break;
         if (!ac_pend) started = 1;
      end
      if (n >= 300) check({tag, "_timeout"}, 1, 0);
      check({tag, "_cr_left"}, cr_exp_q.size(), 0);
      check({tag, "_cd_left"}, cd_exp_q.size(), 0);
      check({tag, "_upd_left"}, upd_exp_q.size(), 0);
   endtask

   task automatic run_snoop(input string tag, input logic [63:0] addr, input logic [3:0] snp,
                            input logic [2:0] st, input logic [4:0] exp_cr, input bit exp_upd,
                            input logic [2:0] exp_ns, input logic [63:0] base);
      issue(addr, snp, st, exp_cr, exp_upd, exp_ns, base);
      wait_idle(tag);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ac_ready"}, snoop_resp_o.ac_ready, 1'b1);
      check({tag, "_cr_valid"}, snoop_resp_o.cr_valid, 1'b0);
      check({tag, "_cd_valid"}, snoop_resp_o.cd_valid, 1'b0);
      check({tag, "_lkp_valid"}, lkp_valid_o, 1'b0);
      check({tag, "_dreq_valid"}, dat_req_valid_o, 1'b0);
      check({tag, "_upd_valid"}, upd_valid_o, 1'b0);
      check({tag, "_dat_ready"}, dat_ready_o, 1'b0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_i = 1'b1;
      snoop_req_i = '0;
      lkp_ready_i = 1'b0;
      lkp_rvalid_i = 1'b0;
      lkp_state_i = '0;
      dat_req_ready_i = 1'b0;
      dat_valid_i = 1'b0;
      dat_data_i = '0;
      upd_ready_i = 1'b0;

      repeat (3) step();
      check_quiet("reset");
      check("reset_cr_payload", snoop_resp_o.cr_resp, 5'b0);
      check("reset_cd_payload", {snoop_resp_o.cd.last, snoop_resp_o.cd.data}, 65'b0);
      rst_pend = 1'b0;
      step();

      // Miss: CR all zero, no data, no update.
      run_snoop("miss", 64'h1000, 4'b0001, 3'b000, 5'b00000, 0, 3'b000, 64'h0);
      // Dirty unique line shared out: full CR, beats 0..7, downgrade to shared clean.
      run_snoop("dirty_share", {$urandom(), $urandom()}, 4'b0001, 3'b111, 5'b11101, 1, 3'b001, 64'h0);
      // ReadUnique on a clean unique line under CD backpressure.
      cd_toggle = 1'b1;
      run_snoop("cd_backpr", {$urandom(), $urandom()}, 4'b0111, 3'b101, 5'b10001, 1, 3'b000,
                {$urandom(), $urandom()});
      cd_toggle = 1'b0;
      // CleanShared on a clean line: no data, state unchanged.
      run_snoop("clean_shared", {$urandom(), $urandom()}, 4'b1000, 3'b101, 5'b11000, 0, 3'b000, 64'h0);
      // CR held off for 10 cycles while the data request completes early.
      lat_chk = 1'b0;
      cr_hold = 10;
      run_snoop("cr_hold", {$urandom(), $urandom()}, 4'b0010, 3'b011, 5'b01101, 1, 3'b001,
                {$urandom(), $urandom()});
      // Data request accepted only after CR has handshaken.
      dreq_hold = 6;
      run_snoop("dreq_late", {$urandom(), $urandom()}, 4'b0001, 3'b011, 5'b01101, 1, 3'b001,
                {$urandom(), $urandom()});
      lat_chk = 1'b1;
      run_snoop("clean_inv_dirty", {$urandom(), $urandom()}, 4'b1001, 3'b111, 5'b10101, 1, 3'b000,
                {$urandom(), $urandom()});
      run_snoop("clean_inv_clean", {$urandom(), $urandom()}, 4'b1001, 3'b001, 5'b00000, 1, 3'b000, 64'h0);
      run_snoop("make_inv", {$urandom(), $urandom()}, 4'b1101, 3'b101, 5'b10000, 1, 3'b000, 64'h0);
      run_snoop("read_nsd_same", {$urandom(), $urandom()}, 4'b0011, 3'b001, 5'b01001, 0, 3'b000,
                {$urandom(), $urandom()});
      run_snoop("read_once", {$urandom(), $urandom()}, 4'b0000, 3'b111, 5'b11001, 0, 3'b000,
                {$urandom(), $urandom()});
      run_snoop("other_code", {$urandom(), $urandom()}, 4'b0100, 3'b011, 5'b00000, 0, 3'b000, 64'h0);
      run_snoop("miss_unique", {$urandom(), $urandom()}, 4'b0111, 3'b110, 5'b00000, 0, 3'b000, 64'h0);

      // Reset pulsed in the middle of the line transfer.
      begin
         int n;
         issue({$urandom(), $urandom()}, 4'b0001, 3'b111, 5'b11101, 1, 3'b001, {$urandom(), $urandom()});
         n = 0;
         while (cd_count < 4 && n < 300) begin
            step();
            n++;
         end
         check("mid_reset_reached_beat4", cd_count, 4);
         rst_pend   = 1'b1;
         dat_active = 1'b0;
         step();
         rst_pend = 1'b0;
         cr_exp_q.delete();
         cd_exp_q.delete();
         upd_exp_q.delete();
         addr_exp_q.delete();
         rv_next       = 1'b0;
         cr_stall_prev = 1'b0;
         cr_done_flag  = 1'b1;
         step();
         check_quiet("mid_reset");
      end
      run_snoop("after_reset", {$urandom(), $urandom()}, 4'b0111, 3'b111, 5'b10101, 1, 3'b000,
                {$urandom(), $urandom()});

      repeat (4) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global bound in case the environment itself stalls.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
